// File: rtl/cpu_wb_pkg.sv
// cpu_wb_pkg: shared definitions for the write-back stage.
//   CPU_XLEN, CPU_GREGIDX_WIDTH : datapath and register-index widths
//   F3_*                        : load size/sign funct3 codes
//   wb_state_e                  : write-back FSM state encoding
package cpu_wb_pkg;

    localparam int unsigned CPU_XLEN          = 32;
    localparam int unsigned CPU_GREGIDX_WIDTH = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StCommit
    } wb_state_e;

endpackage

// File: rtl/cpu_wb_load_ext.sv
// cpu_wb_load_ext: combinational load-data lane select and sign/zero extension.
//   funct3  : load size/sign code
//   addr_lo : low two address bits (byte lane / half lane)
//   rdata   : raw aligned 32-bit memory word
//   data    : extended load result
//   bad     : illegal funct3 or misaligned access
module cpu_wb_load_ext
    import cpu_wb_pkg::*;
#(
    parameter int unsigned XLEN = CPU_XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            bad
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        bad  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH: begin
                data = {{(XLEN-16){half_v[15]}}, half_v};
                bad  = addr_lo[0];
            end
            F3_LW: begin
                data = rdata;
                bad  = (addr_lo != 2'b00);
            end
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_v};
                bad  = addr_lo[0];
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_wb.sv
// cpu_wb: write-back stage feeding the general register file write port.
//   clk, reset           : clock (rising edge), asynchronous active-high reset
//   ex_*                 : retired instruction from execute (valid/ready handshake)
//   mem_rvalid/rdata/err : data-memory load response
//   gregs_hold           : register file busy with backup/restore, writes held off
//   flush                : cancel the in-flight instruction
//   rd_wen/rd_idx/rd_dat : register file write port
//   wb_done              : pulse when an instruction retires
//   load_fault           : pulse on load error, timeout, illegal funct3 or misalignment
module cpu_wb
    import cpu_wb_pkg::*;
#(
    parameter int unsigned XLEN          = CPU_XLEN,
    parameter int unsigned GREGIDX_WIDTH = CPU_GREGIDX_WIDTH,
    parameter int unsigned MEM_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic                     ex_rd_wen,
    input  logic [GREGIDX_WIDTH-1:0] ex_rd_idx,
    input  logic [XLEN-1:0]          ex_result,
    input  logic                     ex_is_load,
    input  logic [2:0]               ex_funct3,
    input  logic [1:0]               ex_addr_lo,
    input  logic                     mem_rvalid,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     mem_err,
    input  logic                     gregs_hold,
    input  logic                     flush,
    output logic                     rd_wen,
    output logic [GREGIDX_WIDTH-1:0] rd_idx,
    output logic [XLEN-1:0]          rd_dat,
    output logic                     wb_done,
    output logic                     load_fault
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT);

    wb_state_e                state_q;
    logic                     cap_wen_q;
    logic [GREGIDX_WIDTH-1:0] cap_idx_q;
    logic [XLEN-1:0]          cap_res_q;
    logic [2:0]               cap_f3_q;
    logic [1:0]               cap_lo_q;
    logic                     drop_q;
    logic [CntW-1:0]          cnt_q;

    logic [XLEN-1:0] ext_data;
    logic            ext_bad;
    logic            commit_go;
    logic            accept;
    logic            in_wait;
    logic            drop_now;
    logic            cnt_last;

    cpu_wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .funct3  (cap_f3_q),
        .addr_lo (cap_lo_q),
        .rdata   (mem_rdata),
        .data    (ext_data),
        .bad     (ext_bad)
    );

    always_comb begin
        commit_go = (state_q == StCommit) && !gregs_hold;
        in_wait   = (state_q == StWaitMem);
        ex_ready  = (state_q == StIdle) || commit_go;
        accept    = ex_valid && ex_ready;
        // A flush arriving together with the response cancels it just like an earlier one.
        drop_now  = drop_q || flush;
        cnt_last  = (cnt_q == CntW'(MEM_TIMEOUT - 1));

        rd_idx     = cap_idx_q;
        rd_dat     = cap_res_q;
        rd_wen     = commit_go && !flush && cap_wen_q && (cap_idx_q != '0);
        wb_done    = commit_go;
        load_fault = in_wait && !drop_now &&
                     (mem_rvalid ? (mem_err || ext_bad) : cnt_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cap_wen_q <= 1'b0;
            cap_idx_q <= '0;
            cap_res_q <= '0;
            cap_f3_q  <= '0;
            cap_lo_q  <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            // Acceptance only happens in IDLE or in a COMMIT cycle that retires.
            cap_wen_q <= ex_rd_wen;
            cap_idx_q <= ex_rd_idx;
            cap_res_q <= ex_result;
            cap_f3_q  <= ex_funct3;
            cap_lo_q  <= ex_addr_lo;
            cnt_q     <= '0;
            drop_q    <= 1'b0;
            state_q   <= ex_is_load ? StWaitMem : StCommit;
        end else begin
            case (state_q)
                StIdle: ;
                StWaitMem: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        drop_q  <= 1'b0;
                        state_q <= StIdle;
                        if (!drop_now && !mem_err && !ext_bad) begin
                            cap_res_q <= ext_data;
                            state_q   <= StCommit;
                        end
                    end else if (cnt_last) begin
                        drop_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StCommit: begin
                    if (!gregs_hold) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
